// File: rtl/pipelined_adder_n_bit_if.sv
// pipelined_adder_n_bit_if
//   Operand/result handshake bundle for pipelined_adder_n_bit.
//   Optional macro: PIPE_ADDER_OVF_EN adds the ovf result bit.
//   Signals:
//     in_valid/in_ready           operand handshake (master -> adder)
//     num1, num2, Cin, sub        operands and mode, WIDTH-bit operands
//     out_valid/out_ready         result handshake (adder -> master)
//     sum, Cout [, ovf]           result
//   Modports: master = operand source / result sink, slave = the adder.
interface pipelined_adder_n_bit_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] num1;
  logic [WIDTH-1:0] num2;
  logic             Cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             Cout;
`ifdef PIPE_ADDER_OVF_EN
  logic             ovf;

  modport master (
    output in_valid, num1, num2, Cin, sub, out_ready,
    input  in_ready, out_valid, sum, Cout, ovf
  );
  modport slave (
    input  in_valid, num1, num2, Cin, sub, out_ready,
    output in_ready, out_valid, sum, Cout, ovf
  );
`else
  modport master (
    output in_valid, num1, num2, Cin, sub, out_ready,
    input  in_ready, out_valid, sum, Cout
  );
  modport slave (
    input  in_valid, num1, num2, Cin, sub, out_ready,
    output in_ready, out_valid, sum, Cout
  );
`endif
endinterface

// File: rtl/pipelined_adder_n_bit.sv
// pipelined_adder_n_bit
//   Pipelined ripple-carry adder/subtractor. The operand is split into
//   STAGE_WIDTH-bit slices; one slice is resolved per stage through a chain
//   of full_adder_1_bit cells, with the carry registered between stages.
//   Latency STAGES = WIDTH/STAGE_WIDTH cycles, throughput 1 op/cycle.
//   sub=0: {Cout,sum} = A + B + Cin
//   sub=1: {Cout,sum} = A + ~B + !Cin   (A - B - Cin, Cout=1 means no borrow)
//   Optional macro: PIPE_ADDER_OVF_EN adds bus.ovf (two's-complement overflow).
//   Ports:
//     clk    rising-edge clock
//     reset  asynchronous active-high reset, clears all stage valid bits
//     bus    pipelined_adder_n_bit_if.slave (operands in, results out)
module pipelined_adder_n_bit #(
  parameter int WIDTH       = 16,
  parameter int STAGE_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  pipelined_adder_n_bit_if.slave bus
);

  localparam int SW_SAFE = (STAGE_WIDTH > 0) ? STAGE_WIDTH : 1;
  localparam int STAGES  = (WIDTH / SW_SAFE > 0) ? WIDTH / SW_SAFE : 1;
  // B' forwarding registers exist only between stages
  localparam int YN      = (STAGES > 1) ? STAGES - 1 : 1;

  generate
    if (STAGE_WIDTH < 1 || WIDTH < STAGE_WIDTH || (WIDTH % SW_SAFE) != 0) begin : g_bad_cfg
      $error("pipelined_adder_n_bit: WIDTH must be a non-zero multiple of STAGE_WIDTH");
    end
  endgenerate

  function automatic logic [1:0] full_adder_1_bit(input logic a, input logic b, input logic cin);
    return {(a & b) | (cin & (a ^ b)), a ^ b ^ cin};
  endfunction

  logic                         advance;
  logic [WIDTH-1:0]             b_prep;
  logic                         carry0;

  // x: resolved sum bits below the current slice, untouched A bits above it
  logic [STAGES-1:0][WIDTH-1:0] x_q;
  logic [STAGES-1:0][WIDTH-1:0] x_nx;
  logic [STAGES-1:0]            c_q;
  logic [STAGES-1:0]            c_nx;
  logic [STAGES-1:0]            v_q;
  // y: B' shifted down so the slice for the next stage sits at bit 0
  logic [YN-1:0][WIDTH-1:0]     y_q;
  logic [YN-1:0][WIDTH-1:0]     y_nx;
`ifdef PIPE_ADDER_OVF_EN
  logic                         msb_cin;
  logic                         ovf_q;
`endif

  assign b_prep  = bus.sub ? ~bus.num2 : bus.num2;
  assign carry0  = bus.Cin ^ bus.sub;
  assign advance = ~v_q[STAGES-1] | bus.out_ready;

  always_comb begin
    logic [WIDTH-1:0] xi;
    logic [WIDTH-1:0] yi;
    logic             ci;
    logic [1:0]       fa;
    xi   = '0;
    yi   = '0;
    ci   = 1'b0;
    fa   = '0;
    x_nx = '0;
    y_nx = '0;
    c_nx = '0;
`ifdef PIPE_ADDER_OVF_EN
    msb_cin = 1'b0;
`endif
    for (int unsigned k = 0; k < STAGES; k++) begin
      if (k == 0) begin
        xi = bus.num1;
        yi = b_prep;
        ci = carry0;
      end else begin
        xi = x_q[k-1];
        yi = y_q[k-1];
        ci = c_q[k-1];
      end
      x_nx[k] = xi;
      for (int unsigned j = 0; j < STAGE_WIDTH; j++) begin
`ifdef PIPE_ADDER_OVF_EN
        if (k == STAGES - 1 && j == STAGE_WIDTH - 1) msb_cin = ci;
`endif
        fa = full_adder_1_bit(xi[k*STAGE_WIDTH + j], yi[j], ci);
        x_nx[k][k*STAGE_WIDTH + j] = fa[0];
        ci = fa[1];
      end
      c_nx[k] = ci;
      if (k < STAGES - 1) y_nx[k] = yi >> STAGE_WIDTH;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v_q   <= '0;
      x_q   <= '0;
      c_q   <= '0;
      y_q   <= '0;
`ifdef PIPE_ADDER_OVF_EN
      ovf_q <= 1'b0;
`endif
    end else if (advance) begin
      // whole pipeline moves as one; bubbles travel as valid=0 slots
      v_q   <= (v_q << 1) | STAGES'(bus.in_valid);
      x_q   <= x_nx;
      c_q   <= c_nx;
      y_q   <= y_nx;
`ifdef PIPE_ADDER_OVF_EN
      ovf_q <= msb_cin ^ c_nx[STAGES-1];
`endif
    end
  end

  assign bus.in_ready  = advance;
  assign bus.out_valid = v_q[STAGES-1];
  assign bus.sum       = x_q[STAGES-1];
  assign bus.Cout      = c_q[STAGES-1];
`ifdef PIPE_ADDER_OVF_EN
  assign bus.ovf       = ovf_q;
`endif

endmodule
